// File: rtl/frac_pkg.sv
// Shared types for the fraction reducer: controller state encoding and datapath width.
package frac_pkg;

   localparam int FRAC_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ZERO,
      CALL,
      WAIT,
      DIV
   } frac_state_t;

endpackage

// File: rtl/nwd.sv
// GCD unit by repeated subtraction. ready is high while idle; out holds the last result.
// Both operands must be non-zero, otherwise the subtraction loop never converges.
module nwd (
   input  logic       clk,
   input  logic       nrst,
   input  logic       start,
   input  logic [7:0] ina,
   input  logic [7:0] inb,
   output logic       ready,
   output logic [7:0] out
);

   logic       r_busy;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [7:0] r_out;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_busy <= 1'b0;
         r_a    <= '0;
         r_b    <= '0;
         r_out  <= '0;
      end else if (!r_busy) begin
         if (start) begin
            r_a    <= ina;
            r_b    <= inb;
            r_busy <= 1'b1;
         end
      end else if (r_a == r_b) begin
         r_out  <= r_a;
         r_busy <= 1'b0;
      end else if (r_a > r_b) begin
         r_a <= r_a - r_b;
      end else begin
         r_b <= r_b - r_a;
      end
   end

   assign ready = ~r_busy;
   assign out   = r_out;

endmodule

// File: rtl/fraction_reduce.sv
// Reduces num/den to lowest terms: GCD from the nwd unit, then exact division of both
// operands by repeated subtraction. Zero operands are resolved without calling nwd.
module fraction_reduce
   import frac_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] num,
   input  logic [7:0] den,
   output logic       ready,
   output logic [7:0] out_num,
   output logic [7:0] out_den,
   output logic       err
);

   frac_state_t       r_state, w_state_next;
   logic [FRAC_W-1:0] r_num, w_num_next;
   logic [FRAC_W-1:0] r_den, w_den_next;
   logic [FRAC_W-1:0] r_g, w_g_next;
   logic [FRAC_W-1:0] r_rn, w_rn_next;
   logic [FRAC_W-1:0] r_rd, w_rd_next;
   logic [FRAC_W-1:0] r_qn, w_qn_next;
   logic [FRAC_W-1:0] r_qd, w_qd_next;
   logic [FRAC_W-1:0] r_out_num, w_out_num_next;
   logic [FRAC_W-1:0] r_out_den, w_out_den_next;
   logic              r_err, w_err_next;

   logic              w_nwd_nrst;
   logic              w_nwd_start;
   logic              w_nwd_ready;
   logic [FRAC_W-1:0] w_nwd_out;
   logic              w_rn_ge;
   logic              w_rd_ge;

   assign w_nwd_nrst  = ~rst;
   assign w_nwd_start = (r_state == CALL);
   assign w_rn_ge     = (r_rn >= r_g);
   assign w_rd_ge     = (r_rd >= r_g);

   // Operands come straight from the latched registers so they stay stable for the whole call.
   nwd u_nwd (
      .clk   (clk),
      .nrst  (w_nwd_nrst),
      .start (w_nwd_start),
      .ina   (r_num),
      .inb   (r_den),
      .ready (w_nwd_ready),
      .out   (w_nwd_out)
   );

   always_comb begin
      w_state_next   = r_state;
      w_num_next     = r_num;
      w_den_next     = r_den;
      w_g_next       = r_g;
      w_rn_next      = r_rn;
      w_rd_next      = r_rd;
      w_qn_next      = r_qn;
      w_qd_next      = r_qd;
      w_out_num_next = r_out_num;
      w_out_den_next = r_out_den;
      w_err_next     = r_err;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_num_next   = num;
               w_den_next   = den;
               w_state_next = (num == '0 || den == '0) ? ZERO : CALL;
            end
         end
         ZERO: begin
            w_out_num_next = '0;
            w_out_den_next = (r_den == '0) ? FRAC_W'(0) : FRAC_W'(1);
            w_err_next     = (r_den == '0);
            w_state_next   = IDLE;
         end
         CALL: begin
            w_state_next = WAIT;
         end
         WAIT: begin
            if (w_nwd_ready) begin
               w_g_next     = w_nwd_out;
               w_rn_next    = r_num;
               w_rd_next    = r_den;
               w_qn_next    = '0;
               w_qd_next    = '0;
               w_state_next = DIV;
            end
         end
         DIV: begin
            // g divides both operands, so both remainders reach zero; done when neither can shrink.
            if (!w_rn_ge && !w_rd_ge) begin
               w_out_num_next = r_qn;
               w_out_den_next = r_qd;
               w_err_next     = 1'b0;
               w_state_next   = IDLE;
            end else begin
               if (w_rn_ge) begin
                  w_rn_next = r_rn - r_g;
                  w_qn_next = r_qn + FRAC_W'(1);
               end
               if (w_rd_ge) begin
                  w_rd_next = r_rd - r_g;
                  w_qd_next = r_qd + FRAC_W'(1);
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_num     <= '0;
         r_den     <= '0;
         r_g       <= '0;
         r_rn      <= '0;
         r_rd      <= '0;
         r_qn      <= '0;
         r_qd      <= '0;
         r_out_num <= '0;
         r_out_den <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_num     <= w_num_next;
         r_den     <= w_den_next;
         r_g       <= w_g_next;
         r_rn      <= w_rn_next;
         r_rd      <= w_rd_next;
         r_qn      <= w_qn_next;
         r_qd      <= w_qd_next;
         r_out_num <= w_out_num_next;
         r_out_den <= w_out_den_next;
         r_err     <= w_err_next;
      end
   end

   assign ready   = (r_state == IDLE);
   assign out_num = r_out_num;
   assign out_den = r_out_den;
   assign err     = r_err;

endmodule

// File: tb/tb_fraction_reduce.sv
// Self-checking bench for fraction_reduce: directed scenarios plus randomized fractions
// compared against a Euclid-based reference.
module tb_fraction_reduce;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] num;
   logic [7:0] den;
   logic       ready;
   logic [7:0] out_num;
   logic [7:0] out_den;
   logic       err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fraction_reduce dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .num     (num),
      .den     (den),
      .ready   (ready),
      .out_num (out_num),
      .out_den (out_den),
      .err     (err)
   );

   function automatic int gcd_ref(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Expected {err, out_num, out_den} for a request.
   function automatic logic [16:0] ref_result(input int n, input int d);
      int g;
      if (d == 0) return {1'b1, 8'd0, 8'd0};
      if (n == 0) return {1'b0, 8'd0, 8'd1};
      g = gcd_ref(n, d);
      return {1'b0, 8'(n / g), 8'(d / g)};
   endfunction

   // Divider cycles: one per subtraction of the larger operand plus the completing cycle.
   function automatic int ref_div_cycles(input int n, input int d);
      int mx;
      mx = (n > d) ? n : d;
      return mx / gcd_ref(n, d) + 1;
   endfunction

   // Presents a request for one cycle; returns on the falling edge after the accepting edge.
   task automatic issue(input logic [7:0] n, input logic [7:0] d);
      @(negedge clk);
      start = 1'b1;
      num   = n;
      den   = d;
      @(negedge clk);
      start = 1'b0;
      num   = 8'($urandom);
      den   = 8'($urandom);
   endtask

   // Counts ready-low samples, nwd-busy samples, nwd.start pulses and nwd.ina deviations.
   task automatic wait_ready(input logic [7:0] exp_ina, output int lowcnt, output int busy,
                             output int starts, output int ina_bad, output bit to);
      lowcnt = 0; busy = 0; starts = 0; ina_bad = 0; to = 1'b0;
      while (ready !== 1'b1 && !to) begin
         lowcnt++;
         if (dut.u_nwd.ready === 1'b0) busy++;
         if (dut.u_nwd.start === 1'b1) starts++;
         if (dut.u_nwd.ina !== exp_ina) ina_bad++;
         if (lowcnt > 2000) to = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; num = '0; den = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({ready, err, out_num, out_den, dut.u_nwd.start} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset: ready=%b err=%b out=%0d/%0d nwd_start=%b, want ready=1 err=0 out=0/0 nwd_start=0",
                  ready, err, out_num, out_den, dut.u_nwd.start);
      end
   endtask

   task automatic test_12_18();
      int lowcnt, busy, starts, ina_bad, div;
      bit to;
      issue(8'd12, 8'd18);
      n_vec++;
      if (ready !== 1'b0) begin
         n_err++; $display("FAIL 12_18_ready_drop: ready=%b want 0", ready);
      end
      wait_ready(8'd12, lowcnt, busy, starts, ina_bad, to);
      n_vec++;
      if (to) begin
         n_err++; $display("FAIL 12_18_timeout: ready never rose");
      end
      n_vec++;
      if ({err, out_num, out_den} !== {1'b0, 8'd2, 8'd3}) begin
         n_err++; $display("FAIL 12_18_result: got %0d/%0d err=%b want 2/3 err=0", out_num, out_den, err);
      end
      // Low span = CALL + WAIT (nwd busy cycles + the cycle it reports ready) + DIV.
      div = lowcnt - 1 - (busy + 1);
      n_vec++;
      if (div !== 4) begin
         n_err++; $display("FAIL 12_18_div_cycles: got %0d want 4", div);
      end
      $display("12/18 -> %0d/%0d err=%b, ready low %0d cycles", out_num, out_den, err, lowcnt);
   endtask

   task automatic test_zero_num();
      int lowcnt, busy, starts, ina_bad;
      bit to;
      issue(8'd0, 8'd5);
      wait_ready(8'd0, lowcnt, busy, starts, ina_bad, to);
      // Falling-edge samples see the ZERO cycle; adding the return edge gives the 2-cycle span.
      n_vec++;
      if (to || lowcnt + 1 !== 2) begin
         n_err++; $display("FAIL zero_num_latency: got %0d want 2", lowcnt + 1);
      end
      n_vec++;
      if ({err, out_num, out_den} !== {1'b0, 8'd0, 8'd1}) begin
         n_err++; $display("FAIL zero_num_result: got %0d/%0d err=%b want 0/1 err=0", out_num, out_den, err);
      end
      n_vec++;
      if (starts !== 0) begin
         n_err++; $display("FAIL zero_num_nwd_start: %0d pulses want 0", starts);
      end
      $display("0/5 -> %0d/%0d err=%b", out_num, out_den, err);
   endtask

   task automatic test_zero_den();
      int lowcnt, busy, starts, ina_bad;
      bit to;
      issue(8'd7, 8'd0);
      wait_ready(8'd7, lowcnt, busy, starts, ina_bad, to);
      n_vec++;
      if (to || {err, out_num, out_den} !== {1'b1, 8'd0, 8'd0} || starts !== 0 || lowcnt + 1 !== 2) begin
         n_err++;
         $display("FAIL zero_den: got %0d/%0d err=%b starts=%0d span=%0d want 0/0 err=1 starts=0 span=2",
                  out_num, out_den, err, starts, lowcnt + 1);
      end
      $display("7/0 -> %0d/%0d err=%b", out_num, out_den, err);
      issue(8'd17, 8'd17);
      wait_ready(8'd17, lowcnt, busy, starts, ina_bad, to);
      n_vec++;
      if (to || {err, out_num, out_den} !== {1'b0, 8'd1, 8'd1}) begin
         n_err++; $display("FAIL after_err: got %0d/%0d err=%b want 1/1 err=0", out_num, out_den, err);
      end
      $display("17/17 -> %0d/%0d err=%b", out_num, out_den, err);
   endtask

   task automatic test_max();
      int lowcnt, busy, starts, ina_bad, div;
      bit to;
      issue(8'd255, 8'd1);
      wait_ready(8'd255, lowcnt, busy, starts, ina_bad, to);
      n_vec++;
      if (to || {err, out_num, out_den} !== {1'b0, 8'd255, 8'd1}) begin
         n_err++; $display("FAIL max_result: got %0d/%0d err=%b want 255/1 err=0", out_num, out_den, err);
      end
      div = lowcnt - 1 - (busy + 1);
      n_vec++;
      if (div !== 256) begin
         n_err++; $display("FAIL max_div_cycles: got %0d want 256", div);
      end
      $display("255/1 -> %0d/%0d err=%b, divide %0d cycles", out_num, out_den, err, div);
   endtask

   task automatic test_busy_start();
      int lowcnt, busy, starts, ina_bad;
      bit to;
      issue(8'd12, 8'd18);
      // Unsolicited request while busy.
      start = 1'b1; num = 8'd9; den = 8'd6;
      @(negedge clk);
      start = 1'b0;
      n_vec++;
      if (ready !== 1'b0 || dut.u_nwd.ina !== 8'd12) begin
         n_err++; $display("FAIL busy_pulse: ready=%b ina=%0d want ready=0 ina=12", ready, dut.u_nwd.ina);
      end
      wait_ready(8'd12, lowcnt, busy, starts, ina_bad, to);
      n_vec++;
      if (to || ina_bad !== 0 || {err, out_num, out_den} !== {1'b0, 8'd2, 8'd3}) begin
         n_err++; $display("FAIL busy_ignore: got %0d/%0d err=%b ina_changes=%0d want 2/3 err=0 ina_changes=0",
                           out_num, out_den, err, ina_bad);
      end
      @(negedge clk);
      n_vec++;
      if (ready !== 1'b1 || out_num !== 8'd2 || out_den !== 8'd3) begin
         n_err++; $display("FAIL busy_not_queued: ready=%b out=%0d/%0d want ready=1 out=2/3", ready, out_num, out_den);
      end
      $display("12/18 with 9/6 pulse -> %0d/%0d err=%b", out_num, out_den, err);
   endtask

   task automatic test_reset_abort();
      int lowcnt, busy, starts, ina_bad;
      bit to;
      issue(8'd200, 8'd150);
      @(negedge clk);
      n_vec++;
      if (dut.u_nwd.ready !== 1'b0) begin
         n_err++; $display("FAIL wait_nwd_busy: nwd.ready=%b want 0", dut.u_nwd.ready);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if ({ready, err, out_num, out_den, dut.u_nwd.ready} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b1}) begin
         n_err++; $display("FAIL abort: ready=%b err=%b out=%0d/%0d nwd_ready=%b want 1 0 0/0 1",
                           ready, err, out_num, out_den, dut.u_nwd.ready);
      end
      issue(8'd200, 8'd150);
      wait_ready(8'd200, lowcnt, busy, starts, ina_bad, to);
      n_vec++;
      if (to || {err, out_num, out_den} !== {1'b0, 8'd4, 8'd3}) begin
         n_err++; $display("FAIL after_abort: got %0d/%0d err=%b want 4/3 err=0", out_num, out_den, err);
      end
      $display("200/150 after abort -> %0d/%0d err=%b", out_num, out_den, err);
   endtask

   task automatic test_random();
      int lowcnt, busy, starts, ina_bad, n, d, exp_low;
      bit to;
      logic [16:0] exp;
      for (int i = 0; i < 40; i++) begin
         n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
         d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
         exp = ref_result(n, d);
         issue(8'(n), 8'(d));
         wait_ready(8'(n), lowcnt, busy, starts, ina_bad, to);
         n_vec++;
         if (to || {err, out_num, out_den} !== exp) begin
            n_err++; $display("FAIL rand_result %0d/%0d: got %0d/%0d err=%b want %0d/%0d err=%b",
                              n, d, out_num, out_den, err, exp[15:8], exp[7:0], exp[16]);
         end
         if (n == 0 || d == 0) exp_low = 1;
         else exp_low = 1 + (busy + 1) + ref_div_cycles(n, d);
         n_vec++;
         if (lowcnt !== exp_low || starts !== ((n == 0 || d == 0) ? 0 : 1)) begin
            n_err++; $display("FAIL rand_latency %0d/%0d: low=%0d starts=%0d want low=%0d", n, d, lowcnt, starts, exp_low);
         end
         $display("%0d/%0d -> %0d/%0d err=%b, ready low %0d cycles", n, d, out_num, out_den, err, lowcnt);
      end
   endtask

   initial begin
      test_reset();
      test_12_18();
      test_zero_num();
      test_zero_den();
      test_max();
      test_busy_start();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
